// File: rtl/apb_req_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : apb_req_arbiter_if
//  Brief    : Bundles the requester handshake, response return and APB master
//             command/status signals shared by apb_req_arbiter and its users.
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    // Requester side: request payload in, acceptance and response out
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;

    // APB master front-end: commands out, observed bus status in
    logic               m_transfer;
    logic               m_read_write;
    logic [AW-1:0]      m_write_paddr;
    logic [AW-1:0]      m_read_paddr;
    logic [DW-1:0]      m_write_data;
    logic               m_penable;
    logic               m_pready;
    logic               m_pslverr;
    logic [DW-1:0]      m_rdata;

    logic               busy;

    // Arbiter view: consumes requests and bus status, drives grants,
    // responses and master commands.
    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  m_penable, m_pready, m_pslverr, m_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output m_transfer, m_read_write, m_write_paddr, m_read_paddr, m_write_data,
        output busy
    );

    // Environment view: the requesters together with the APB master.
    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output m_penable, m_pready, m_pslverr, m_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  m_transfer, m_read_write, m_write_paddr, m_read_paddr, m_write_data,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : apb_req_arbiter
//  Brief    : Round-robin scheduler sharing one APB master front-end between
//             NREQ requesters. One request in flight at a time; commands are
//             held stable until completion, slave error or timeout, then the
//             response is returned to the granted requester.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,   // active-high asynchronous reset
    apb_req_arbiter_if.master bus
);

    localparam int c_GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT - 1);
    localparam logic [c_GW-1:0] c_GLAST = c_GW'(NREQ - 1);
    localparam logic [NREQ-1:0] c_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_GW-1:0]    r_gnt;
    logic [c_GW-1:0]    r_last_gnt;
    logic [c_TW-1:0]    r_tcnt;
    logic               r_write;

    logic [NREQ-1:0]    r_rsp_valid;
    logic [DW-1:0]      r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_m_transfer;
    logic               r_m_read_write;
    logic [AW-1:0]      r_m_write_paddr;
    logic [AW-1:0]      r_m_read_paddr;
    logic [DW-1:0]      r_m_write_data;
    logic               r_busy;

    logic               w_any;
    logic [c_GW-1:0]    w_win;
    logic [c_GW-1:0]    w_idx;
    logic               w_sel_write;
    logic [AW-1:0]      w_sel_addr;
    logic [DW-1:0]      w_sel_wdata;
    logic               w_done;
    logic               w_done_err;
    logic [DW-1:0]      w_done_rdata;
    logic [NREQ-1:0]    w_ready;

    assign w_any = |bus.req_valid;

    // Round-robin pick: first requesting index after last_gnt, wrapping.
    // Walking offsets from farthest to nearest lets the nearest one win.
    always_comb begin
        w_win = r_last_gnt;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = c_GW'((int'(r_last_gnt) + k) % NREQ);
            if (bus.req_valid[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    // Payload mux: pick the winning requester's lane of the flat buses.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == c_GW'(i)) begin
                w_sel_write = bus.req_write[i];
                w_sel_addr  = bus.req_addr[i*AW +: AW];
                w_sel_wdata = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    // Exit conditions for XFER in priority order: slave error, normal
    // completion, then timeout (so a completion on the last allowed cycle
    // still counts as success).
    always_comb begin
        w_done       = 1'b0;
        w_done_err   = 1'b0;
        w_done_rdata = '0;
        if (bus.m_pslverr) begin
            w_done     = 1'b1;
            w_done_err = 1'b1;
        end else if (bus.m_penable && bus.m_pready) begin
            w_done       = 1'b1;
            w_done_rdata = r_write ? '0 : bus.m_rdata;
        end else if (r_tcnt == c_TLAST) begin
            w_done     = 1'b1;
            w_done_err = 1'b1;
        end
    end

    // Acceptance is signalled in the same IDLE cycle the request is seen;
    // it is forced low while reset is held so every output reads zero.
    always_comb begin
        w_ready = '0;
        if ((r_state == S_IDLE) && w_any && !PRESETn) begin
            w_ready = c_ONE << w_win;
        end
    end

    // Scheduler state machine with registered command and response outputs.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            r_state         <= S_IDLE;
            r_gnt           <= '0;
            r_last_gnt      <= c_GLAST;
            r_tcnt          <= '0;
            r_write         <= 1'b0;
            r_rsp_valid     <= '0;
            r_rsp_rdata     <= '0;
            r_rsp_err       <= 1'b0;
            r_m_transfer    <= 1'b0;
            r_m_read_write  <= 1'b0;
            r_m_write_paddr <= '0;
            r_m_read_paddr  <= '0;
            r_m_write_data  <= '0;
            r_busy          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state        <= S_XFER;
                        r_gnt          <= w_win;
                        r_write        <= w_sel_write;
                        r_tcnt         <= '0;
                        r_busy         <= 1'b1;
                        r_m_transfer   <= 1'b1;
                        r_m_read_write <= ~w_sel_write;
                        if (w_sel_write) begin
                            r_m_write_paddr <= w_sel_addr;
                            r_m_write_data  <= w_sel_wdata;
                            r_m_read_paddr  <= '0;
                        end else begin
                            r_m_write_paddr <= '0;
                            r_m_write_data  <= '0;
                            r_m_read_paddr  <= w_sel_addr;
                        end
                    end
                end

                S_XFER: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    if (w_done) begin
                        r_state         <= S_RESP;
                        r_rsp_valid     <= c_ONE << r_gnt;
                        r_rsp_err       <= w_done_err;
                        r_rsp_rdata     <= w_done_rdata;
                        r_m_transfer    <= 1'b0;
                        r_m_read_write  <= 1'b0;
                        r_m_write_paddr <= '0;
                        r_m_read_paddr  <= '0;
                        r_m_write_data  <= '0;
                    end
                end

                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= '0;
                    r_last_gnt  <= r_gnt;
                    r_busy      <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = w_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.m_transfer    = r_m_transfer;
    assign bus.m_read_write  = r_m_read_write;
    assign bus.m_write_paddr = r_m_write_paddr;
    assign bus.m_read_paddr  = r_m_read_paddr;
    assign bus.m_write_data  = r_m_write_data;
    assign bus.busy          = r_busy;

endmodule
`default_nettype wire
